// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the uart_loader boot image loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_SAMPLE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [2:0] {
    PH_MAGIC,
    PH_CNT0,
    PH_CNT1,
    PH_DATA,
    PH_CSUM
  } phase_t;

  localparam int          RX_VALID_BIT = 8;
  localparam logic [31:0] UART_RX_ADR  = 32'h0000_0000;

endpackage

// File: rtl/uart_loader_gap_timer.sv
// Inter-byte gap watchdog: reload on each received byte, count down while running,
// flag expiry on the cycle the count would reach zero.
module uart_loader_gap_timer #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  logic [23:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TIMEOUT;
    end else if (run && (cnt != 24'd0)) begin
      cnt <= cnt - 24'd1;
    end
  end

  // Expiry lands exactly TIMEOUT running cycles after the last reload.
  assign expire = run && !load && (cnt <= 24'd1);

endmodule

// File: rtl/uart_loader.sv
// Boot loader: polls the uart RX register, parses a magic/count/data/checksum frame
// and writes assembled little-endian words to memory.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [7:0]  MAGIC     = 8'hA5,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic [31:0] uart_adr_o,
  output logic        uart_stb_o,
  output logic        uart_we_o,
  input  logic [31:0] uart_dat_i,
  input  logic        uart_ack_i,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic        mem_we_o,
  input  logic        mem_ack_i,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state;
  phase_t      phase;
  logic [15:0] word_cnt;
  logic [15:0] idx;
  logic [15:0] idx_next;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [31:0] word;
  logic [31:0] next_word;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        gap_load;
  logic        gap_run;
  logic        gap_expire;
  logic        unused_dat;

  assign uart_adr_o = UART_RX_ADR;
  assign uart_we_o  = 1'b0;
  assign rx_valid   = uart_dat_i[RX_VALID_BIT];
  assign rx_byte    = uart_dat_i[7:0];
  assign unused_dat = ^uart_dat_i[31:9];
  assign next_word  = {rx_byte, word[31:8]};
  assign idx_next   = idx + 16'd1;

  assign gap_load = ((state == S_IDLE) && start) || ((state == S_SAMPLE) && rx_valid);
  assign gap_run  = ((state == S_POLL) || (state == S_SAMPLE)) && (phase != PH_MAGIC);

  uart_loader_gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .load   (gap_load),
    .run    (gap_run),
    .expire (gap_expire)
  );

  // Word assembly register; a partial word is simply overwritten by the next four bytes.
  always_ff @(posedge sys_clk) begin
    if ((state == S_SAMPLE) && rx_valid && (phase == PH_DATA)) begin
      word <= next_word;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      phase      <= PH_MAGIC;
      word_cnt   <= '0;
      idx        <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      uart_stb_o <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_adr_o  <= '0;
      mem_dat_o  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done       <= 1'b0;
            err        <= 1'b0;
            csum       <= '0;
            idx        <= '0;
            byte_idx   <= '0;
            word_cnt   <= '0;
            phase      <= PH_MAGIC;
            busy       <= 1'b1;
            uart_stb_o <= 1'b1;
            state      <= S_POLL;
          end
        end

        S_POLL: begin
          if (gap_expire) begin
            uart_stb_o <= 1'b0;
            err        <= 1'b1;
            state      <= S_ERR;
          end else if (uart_ack_i) begin
            uart_stb_o <= 1'b0;
            state      <= S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          if (rx_valid) begin
            uart_stb_o <= 1'b1;
            state      <= S_POLL;
            case (phase)
              PH_MAGIC: begin
                if (rx_byte == MAGIC) phase <= PH_CNT0;
              end
              PH_CNT0: begin
                word_cnt[7:0] <= rx_byte;
                csum          <= csum ^ rx_byte;
                phase         <= PH_CNT1;
              end
              PH_CNT1: begin
                word_cnt[15:8] <= rx_byte;
                csum           <= csum ^ rx_byte;
                phase          <= ({rx_byte, word_cnt[7:0]} == 16'd0) ? PH_CSUM : PH_DATA;
              end
              PH_DATA: begin
                csum     <= csum ^ rx_byte;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  uart_stb_o <= 1'b0;
                  mem_we_o   <= 1'b1;
                  mem_adr_o  <= BASE_ADDR + {14'd0, idx, 2'b00};
                  mem_dat_o  <= next_word;
                  state      <= S_WRITE;
                end
              end
              PH_CSUM: begin
                uart_stb_o <= 1'b0;
                if (rx_byte == csum) begin
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  err   <= 1'b1;
                  state <= S_ERR;
                end
              end
              default: phase <= PH_MAGIC;
            endcase
          end else if (gap_expire) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else begin
            uart_stb_o <= 1'b1;
            state      <= S_POLL;
          end
        end

        // Address and data stay registered and untouched until the memory accepts.
        S_WRITE: begin
          if (mem_ack_i) begin
            mem_we_o   <= 1'b0;
            idx        <= idx_next;
            phase      <= (idx_next == word_cnt) ? PH_CSUM : PH_DATA;
            uart_stb_o <= 1'b1;
            state      <= S_POLL;
          end
        end

        S_DONE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          uart_stb_o <= 1'b0;
          mem_we_o   <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed plus randomized bench for uart_loader against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_loader;

  localparam logic [7:0]  MAGIC = 8'hA5;
  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam logic [23:0] TMO   = 24'd40;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [31:0] uart_adr_o;
  logic        uart_stb_o;
  logic        uart_we_o;
  logic [31:0] uart_dat_i = '0;
  logic        uart_ack_i;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        mem_we_o;
  logic        mem_ack_i;
  logic        busy;
  logic        done;
  logic        err;

  uart_loader #(
    .MAGIC    (MAGIC),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .uart_adr_o(uart_adr_o),
    .uart_stb_o(uart_stb_o),
    .uart_we_o (uart_we_o),
    .uart_dat_i(uart_dat_i),
    .uart_ack_i(uart_ack_i),
    .mem_adr_o (mem_adr_o),
    .mem_dat_o (mem_dat_o),
    .mem_we_o  (mem_we_o),
    .mem_ack_i (mem_ack_i),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_pop = 0;
  int stall = 0;
  int stall_req = 0;
  int we_len = 0;
  int last_we_len = 0;
  int viol = 0;
  logic prev_stb = 1'b0;
  logic ack_prev = 1'b0;
  logic [31:0] hold_adr, hold_dat;

  logic [7:0]  rx_q[$];
  logic [7:0]  frame[$];
  logic [31:0] got_adr[$], got_dat[$];
  logic [31:0] exp_adr[$], exp_dat[$];
  logic        exp_done, exp_err;

  assign uart_ack_i = uart_stb_o;
  assign mem_ack_i  = mem_we_o && (stall >= stall_req);

  // uart RX register model (read-once), memory model and bus-protocol monitor
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (uart_stb_o && rx_q.size() > 0) begin
      uart_dat_i <= {23'd0, 1'b1, rx_q.pop_front()};
      last_pop   <= cyc;
    end else begin
      uart_dat_i <= 32'd0;
    end
    if (mem_we_o && !mem_ack_i) stall <= stall + 1;
    else stall <= 0;
    if (mem_we_o) begin
      if (we_len == 0) begin
        hold_adr = mem_adr_o;
        hold_dat = mem_dat_o;
      end else if (mem_adr_o !== hold_adr || mem_dat_o !== hold_dat) begin
        viol++;
      end
      we_len++;
      if (mem_ack_i) begin
        got_adr.push_back(mem_adr_o);
        got_dat.push_back(mem_dat_o);
        last_we_len = we_len;
        we_len = 0;
      end
    end else begin
      we_len = 0;
    end
    if (uart_stb_o && (prev_stb || mem_we_o)) viol++;
    if (ack_prev && !uart_stb_o && !sys_rst) viol++;
    prev_stb <= uart_stb_o;
    ack_prev <= mem_we_o && mem_ack_i;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d required=finish", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: parse the byte stream as a frame, independent of any FSM detail.
  task automatic model(input logic [7:0] s[$]);
    int i;
    logic [15:0] n;
    logic [7:0]  cs;
    exp_adr.delete();
    exp_dat.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    i = 0;
    while (i < s.size() && s[i] != MAGIC) i++;
    i++;
    if (i + 2 > s.size()) begin
      exp_err = 1'b1;
      return;
    end
    n  = {s[i+1], s[i]};
    cs = s[i] ^ s[i+1];
    i += 2;
    for (int k = 0; k < int'(n); k++) begin
      if (i + 4 > s.size()) begin
        exp_err = 1'b1;
        return;
      end
      exp_adr.push_back(BASE + 32'(4 * k));
      exp_dat.push_back({s[i+3], s[i+2], s[i+1], s[i]});
      cs ^= s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
      i += 4;
    end
    if (i >= s.size()) exp_err = 1'b1;
    else if (s[i] == cs) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic build(input int n, input int garbage, input bit bad);
    logic [7:0] cs, b;
    frame.delete();
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(0, 255));
      if (b == MAGIC) b = 8'h00;
      frame.push_back(b);
    end
    frame.push_back(MAGIC);
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    cs = 8'(n) ^ 8'(n >> 8);
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      frame.push_back(b);
      cs ^= b;
    end
    frame.push_back(bad ? ~cs : cs);
  endtask

  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit mid_start);
    bit seen;
    model(frame);
    got_adr.delete();
    got_dat.delete();
    foreach (frame[j]) rx_q.push_back(frame[j]);
    pulse_start();
    seen = 1'b0;
    for (int t = 0; t < 4000 && !seen; t++) begin
      @(negedge sys_clk);
      start = (mid_start && t == 6) ? busy : 1'b0;
      if (done || err) seen = 1'b1;
    end
    start = 1'b0;
    check({tag, " finished"}, 32'(seen), 32'd1);
    @(negedge sys_clk);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'(exp_done));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " nwrites"}, 32'(got_adr.size()), 32'(exp_adr.size()));
    foreach (exp_adr[k]) begin
      if (k < got_adr.size()) begin
        check($sformatf("%s adr%0d", tag, k), got_adr[k], exp_adr[k]);
        check($sformatf("%s dat%0d", tag, k), got_dat[k], exp_dat[k]);
      end
    end
    check({tag, " rx drained"}, 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    int err_cyc;
    int v0;
    bit seen;
    sys_rst = 1'b1;
    start   = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst stb", 32'(uart_stb_o), 32'd0);
    check("rst uart_we", 32'(uart_we_o), 32'd0);
    check("rst uart_adr", uart_adr_o, 32'd0);
    check("rst mem_we", 32'(mem_we_o), 32'd0);
    check("rst mem_adr", mem_adr_o, 32'd0);
    check("rst mem_dat", mem_dat_o, 32'd0);
    check("rst flags", {29'd0, busy, done, err}, 32'd0);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Two-word image from the reference stream
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h8A};
    run_frame("A", 1'b0);
    check("A word0", (got_dat.size() > 0) ? got_dat[0] : 32'hX, 32'h4433_2211);
    check("A word1", (got_dat.size() > 1) ? got_dat[1] : 32'hX, 32'h8877_6655);
    check("A adr1", (got_adr.size() > 1) ? got_adr[1] : 32'hX, BASE + 32'd4);

    // Leading garbage then an empty image
    frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("B", 1'b0);
    check("B no writes", 32'(got_adr.size()), 32'd0);

    // Corrupted checksum: words still land, err raised
    frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h55, 8'h66, 8'h77, 8'h88, 8'h75};
    run_frame("C", 1'b0);

    // Truncated frame: timeout measured from the SAMPLE that consumed the last byte
    got_adr.delete();
    got_dat.delete();
    frame = '{8'hA5, 8'h01, 8'h00, 8'h11};
    foreach (frame[j]) rx_q.push_back(frame[j]);
    pulse_start();
    seen = 1'b0;
    err_cyc = 0;
    for (int t = 0; t < 600 && !seen; t++) begin
      @(negedge sys_clk);
      if (err) begin
        seen = 1'b1;
        err_cyc = cyc;
      end
    end
    check("D err seen", 32'(seen), 32'd1);
    // the consuming SAMPLE ends two edges after the pop edge recorded by the uart model
    check("D gap cycles", 32'(err_cyc - (last_pop + 2)), 32'(TMO));
    check("D done", 32'(done), 32'd0);
    check("D no writes", 32'(got_adr.size()), 32'd0);
    repeat (2) @(negedge sys_clk);

    // Memory stalls five cycles on every write
    stall_req = 5;
    v0 = viol;
    build(2, 0, 1'b0);
    run_frame("E", 1'b0);
    check("E write length", 32'(last_we_len), 32'd6);
    check("E bus protocol", 32'(viol - v0), 32'd0);
    stall_req = 0;

    // Reset in the middle of the data phase, then a fresh image
    build(3, 0, 1'b0);
    foreach (frame[j]) rx_q.push_back(frame[j]);
    got_adr.delete();
    got_dat.delete();
    pulse_start();
    for (int t = 0; t < 400 && got_adr.size() == 0; t++) @(negedge sys_clk);
    check("F first write seen", 32'(got_adr.size()), 32'd1);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check("F rst stb", 32'(uart_stb_o), 32'd0);
    check("F rst mem", {mem_adr_o[30:0], mem_we_o}, 32'd0);
    check("F rst dat", mem_dat_o, 32'd0);
    check("F rst flags", {29'd0, busy, done, err}, 32'd0);
    repeat (2) @(negedge sys_clk);
    rx_q.delete();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    build(2, 1, 1'b0);
    run_frame("F", 1'b0);

    // Randomized frames, stalls, corruptions and ignored start pulses
    for (int r = 0; r < 10; r++) begin
      v0 = viol;
      stall_req = $urandom_range(0, 3);
      build($urandom_range(1, 5), $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
      run_frame($sformatf("R%0d", r), 1'($urandom_range(0, 1)));
      check($sformatf("R%0d bus protocol", r), 32'(viol - v0), 32'd0);
    end
    stall_req = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
